// File: rtl/residu_filter.sv
// G.729 LPC inverse filter: y[n] = round(shl(sum ap[j]*x[n-j], 3)) over scratch memory.
// Latency 34+35*lg cycles from start to done; no backpressure, memory answers in fixed 2 cycles.
module residu_filter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LG_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] A,
    input  logic [ADDR_W-1:0] X,
    input  logic [ADDR_W-1:0] Y,
    input  logic [LG_W-1:0]   lg,
    input  logic [DATA_W-1:0] readIn,
    output logic [ADDR_W-1:0] resReadRequested,
    output logic [ADDR_W-1:0] resWriteRequested,
    output logic [DATA_W-1:0] resOut,
    output logic              resWrite,
    output logic              done
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_ADDR, S_LOAD_WAIT, S_LOAD_CAP,
        S_TAP_ADDR, S_TAP_WAIT, S_TAP_CAP, S_ROUND, S_WRITE, S_DONE
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_a, r_x, r_y;
    logic [LG_W-1:0]    r_lg, r_n;
    logic [3:0]         r_k, r_j;
    logic [31:0]        r_acc;
    logic [15:0]        r_ap [0:10];
    logic [ADDR_W-1:0]  r_rd_addr, r_wr_addr;
    logic [DATA_W-1:0]  r_wr_dat;
    logic               r_wr, r_done;

    logic [15:0]        w_x, w_coef, w_y;
    logic signed [31:0] w_prod;
    logic [31:0]        w_lmult, w_mac, w_acc_next, w_shl;
    logic [32:0]        w_mac_sum, w_rnd;
    logic [ADDR_W-1:0]  w_n_ext;
    logic [LG_W-1:0]    w_n1;
    logic               w_unused;

    assign w_x    = readIn[15:0];
    assign w_coef = r_ap[r_j];
    assign w_prod = $signed(w_coef) * $signed(w_x);
    // Only -1 * -1 overflows the doubled product.
    assign w_lmult = (w_coef == 16'h8000 && w_x == 16'h8000) ? 32'h7FFF_FFFF
                                                              : {w_prod[30:0], 1'b0};
    assign w_mac_sum = {r_acc[31], r_acc} + {w_lmult[31], w_lmult};
    assign w_mac = (w_mac_sum[32] != w_mac_sum[31])
                 ? (w_mac_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                 : w_mac_sum[31:0];
    assign w_acc_next = (r_j == 4'd0) ? w_lmult : w_mac;

    // Shift by 3 is lossless only when the top four bits are all sign copies.
    assign w_shl = (r_acc[31:28] == 4'h0 || r_acc[31:28] == 4'hF) ? {r_acc[28:0], 3'b000}
                 : (r_acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    assign w_rnd = {w_shl[31], w_shl} + 33'h0_0000_8000;
    assign w_y   = (w_rnd[32] != w_rnd[31]) ? 16'h7FFF : w_rnd[31:16];

    assign w_n_ext  = ADDR_W'(r_n);
    assign w_n1     = r_n + LG_W'(1);
    assign w_unused = ^{readIn[DATA_W-1:16], w_prod[31], w_rnd[15:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_lg      <= '0;
            r_n       <= '0;
            r_k       <= '0;
            r_j       <= '0;
            r_acc     <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_dat  <= '0;
            r_wr      <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < 11; i++) r_ap[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The cycle showing done is also IDLE; a start there is dropped.
                    if (start && !r_done) begin
                        r_a       <= A;
                        r_x       <= X;
                        r_y       <= Y;
                        r_lg      <= lg;
                        r_k       <= 4'd0;
                        r_rd_addr <= A;
                        r_state   <= S_LOAD_ADDR;
                    end
                end
                S_LOAD_ADDR: r_state <= S_LOAD_WAIT;
                S_LOAD_WAIT: r_state <= S_LOAD_CAP;
                S_LOAD_CAP: begin
                    r_ap[r_k] <= w_x;
                    if (r_k == 4'd10) begin
                        r_n       <= '0;
                        r_j       <= 4'd0;
                        r_acc     <= '0;
                        r_rd_addr <= r_x;
                        r_state   <= (r_lg == '0) ? S_DONE : S_TAP_ADDR;
                    end else begin
                        r_k       <= r_k + 4'd1;
                        r_rd_addr <= r_a + ADDR_W'(r_k + 4'd1);
                        r_state   <= S_LOAD_ADDR;
                    end
                end
                S_TAP_ADDR: r_state <= S_TAP_WAIT;
                S_TAP_WAIT: r_state <= S_TAP_CAP;
                S_TAP_CAP: begin
                    r_acc <= w_acc_next;
                    if (r_j == 4'd10) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_j       <= r_j + 4'd1;
                        r_rd_addr <= r_x + w_n_ext - ADDR_W'(r_j + 4'd1);
                        r_state   <= S_TAP_ADDR;
                    end
                end
                S_ROUND: begin
                    r_wr_addr <= r_y + w_n_ext;
                    r_wr_dat  <= {{(DATA_W-16){w_y[15]}}, w_y};
                    r_wr      <= 1'b1;
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    r_wr <= 1'b0;
                    r_n  <= w_n1;
                    r_j  <= 4'd0;
                    if (w_n1 < r_lg) begin
                        r_rd_addr <= r_x + ADDR_W'(w_n1);
                        r_state   <= S_TAP_ADDR;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign resReadRequested  = r_rd_addr;
    assign resWriteRequested = r_wr_addr;
    assign resOut            = r_wr_dat;
    assign resWrite          = r_wr;
    assign done              = r_done;

endmodule

// File: tb/tb_residu_filter.sv
// Bench for residu_filter: 2-cycle scratch memory model, write scoreboard, timing and abort checks.
module tb_residu_filter;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] A, X, Y;
    logic [5:0]  lg;
    logic [31:0] readIn;
    logic [11:0] resReadRequested, resWriteRequested;
    logic [31:0] resOut;
    logic        resWrite, done;

    residu_filter dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .X(X), .Y(Y), .lg(lg),
        .readIn(readIn), .resReadRequested(resReadRequested),
        .resWriteRequested(resWriteRequested), .resOut(resOut),
        .resWrite(resWrite), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    logic [31:0] rd_pipe;
    always @(posedge clk) begin
        rd_pipe <= mem[resReadRequested];
        readIn  <= rd_pipe;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_err = 0, n_chk = 0;
    logic [43:0] sb [$];
    logic [43:0] sb_e;
    int          wr_times [$];
    int          done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resWrite === 1'b1) begin
            wr_times.push_back(cyc);
            if (sb.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                sb_e = sb.pop_front();
                chk("wr_addr", resWriteRequested, sb_e[43:32]);
                chk("wr_data", resOut, sb_e[31:0]);
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Reference residual from integer arithmetic with explicit clamping.
    function automatic logic [15:0] ref_y(input logic [11:0] a, input logic [11:0] x, input int n);
        longint acc, p, s;
        logic [11:0] xa, aa;
        acc = 0;
        for (int j = 0; j < 11; j++) begin
            aa = a + 12'(j);
            xa = x + 12'(n) - 12'(j);
            p = longint'($signed(mem[aa][15:0])) * longint'($signed(mem[xa][15:0])) * 2;
            p = sat32(p);
            acc = (j == 0) ? p : sat32(acc + p);
        end
        s = sat32(acc * 8);
        s = sat32(s + 32768);
        return 16'(s >>> 16);
    endfunction

    task automatic push_exp(input logic [11:0] y, input int n, input logic [15:0] v);
        sb.push_back({y + 12'(n), {{16{v[15]}}, v}});
    endtask

    task automatic run(input logic [11:0] a, input logic [11:0] x, input logic [11:0] y,
                       input logic [5:0] l);
        int rel, t0;
        bit got;
        wr_times.delete();
        done_cnt = 0;
        @(negedge clk);
        A = a; X = x; Y = y; lg = l; start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        A = ~a; X = ~x; Y = ~y; lg = ~l;
        got = 1'b0;
        for (int c = 0; c < 34 + 35 * int'(l) + 10 && !got; c++) begin
            @(negedge clk);
            rel = cyc - t0;
            start = (rel == 50);
            if (rel <= 30 && rel % 3 == 0)
                chk("rd_addr", resReadRequested, a + 12'(rel / 3));
            if (done === 1'b1) begin
                got = 1'b1;
                chk("latency", rel, 34 + 35 * int'(l));
            end
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("wr_count", wr_times.size(), l);
        for (int i = 1; i < wr_times.size(); i++)
            chk("wr_spacing", wr_times[i] - wr_times[i-1], 35);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic setup_identity();
        mem[12'h100] = 32'd4096;
        for (int n = 0; n < 40; n++) mem[12'h200 + 12'(n)] = 32'(n + 1);
    endtask

    initial begin
        int t1, rel;
        bit got;
        #1ms;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int t0, t1;
        bit got;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        reset = 1'b0; start = 1'b0; A = '0; X = '0; Y = '0; lg = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_wr", resWrite, 0);
        chk("rst_rdaddr", resReadRequested, 0);
        chk("rst_wraddr", resWriteRequested, 0);
        chk("rst_out", resOut, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // identity filter, 40 samples
        setup_identity();
        for (int n = 0; n < 40; n++) push_exp(12'h400, n, 16'(n + 1));
        run(12'h100, 12'h200, 12'h400, 6'd40);

        // first difference using history
        mem[12'h010] = 32'h0000_1000;
        mem[12'h011] = 32'h0000_F000;
        mem[12'h2FF] = 32'd100;
        mem[12'h300] = 32'd300;
        mem[12'h301] = 32'd250;
        sb.push_back({12'h500, 32'h0000_00C8});
        sb.push_back({12'h501, 32'hFFFF_FFCE});
        run(12'h010, 12'h300, 12'h500, 6'd2);

        // saturation corners
        mem[12'h020] = 32'h0000_7FFF;
        mem[12'h600] = 32'h0000_7FFF;
        sb.push_back({12'h700, 32'h0000_7FFF});
        run(12'h020, 12'h600, 12'h700, 6'd1);
        mem[12'h600] = 32'h0000_8000;
        sb.push_back({12'h700, 32'hFFFF_8000});
        run(12'h020, 12'h600, 12'h700, 6'd1);
        mem[12'h020] = 32'h0000_8000;
        sb.push_back({12'h700, 32'h0000_7FFF});
        run(12'h020, 12'h600, 12'h700, 6'd1);

        // empty job: only the coefficient load
        run(12'h030, 12'h600, 12'h700, 6'd0);

        // random coefficients and signal against the reference model
        for (int j = 0; j < 11; j++) mem[12'h040 + 12'(j)] = {16'h0, 16'($urandom)};
        for (int i = -10; i < 12; i++) mem[12'h800 + 12'(i)] = {16'h0, 16'($urandom)};
        for (int n = 0; n < 12; n++) push_exp(12'h900, n, ref_y(12'h040, 12'h800, n));
        run(12'h040, 12'h800, 12'h900, 6'd12);

        // start held across the done cycle: only the following IDLE cycle accepts it
        done_cnt = 0;
        @(negedge clk);
        A = 12'h030; X = 12'h600; Y = 12'h700; lg = 6'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        if (!got) chk("b2b_first_timeout", 0, 1);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        t1 = cyc;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                chk("b2b_latency", cyc - t1, 34);
            end
        end
        if (!got) chk("b2b_timeout", 0, 1);
        repeat (2) @(negedge clk);

        // reset during sample 5 aborts cleanly, then a full rerun
        wr_times.delete();
        done_cnt = 0;
        for (int n = 0; n < 40; n++) push_exp(12'h400, n, 16'(n + 1));
        @(negedge clk);
        A = 12'h100; X = 12'h200; Y = 12'h400; lg = 6'd40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400 && wr_times.size() < 5; c++) @(negedge clk);
        chk("abort_reached", wr_times.size(), 5);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_wr", resWrite, 0);
        chk("abort_done", done, 0);
        chk("abort_out", resOut, 0);
        sb.delete();
        wr_times.delete();
        done_cnt = 0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        chk("abort_no_wr", wr_times.size(), 0);
        chk("abort_no_done", done_cnt, 0);
        for (int n = 0; n < 40; n++) push_exp(12'h400, n, 16'(n + 1));
        run(12'h100, 12'h200, 12'h400, 6'd40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
